// File: rtl/edo_xseq.sv
// rtl/edo_xseq.sv - abscissa sequencer and result capture around the ODE solver
`timescale 1ns/1ps
module edo_xseq #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [15:0]  x0,
    input  logic signed [15:0]  h,
    input  logic        [7:0]   nsteps,
    input  logic                busy,
    input  logic signed [15:0]  yres,
    output logic                go,
    output logic signed [15:0]  xin,
    output logic                stop,
    output logic                running,
    output logic                finished,
    output logic                err,
    output logic                sat,
    output logic        [AW:0]  count,
    input  logic        [AW-1:0] rd_addr,
    output logic signed [15:0]  rd_data
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_NEXT, S_DONE
    } state_t;

    state_t              state, next_state;
    logic signed [15:0]  h_q;
    logic        [7:0]   n_q;
    logic        [7:0]   step_cnt;
    logic        [7:0]   step_inc;
    logic        [TW-1:0] wcnt;
    logic                waiting;
    logic                timeout;
    logic                abort;
    logic                last_step;
    logic                wr_en;
    logic signed [16:0]  sum17;
    logic                sum_ovf;
    logic signed [15:0]  sum_sat;
    logic signed [15:0]  mem [DEPTH];

    assign step_inc  = step_cnt + 8'd1;
    assign last_step = (step_inc == n_q);
    assign waiting   = (state == S_WAIT_HI && !busy) || (state == S_WAIT_LO && busy);
    assign timeout   = (wcnt == TW'(TIMEOUT - 1));
    assign abort     = waiting && timeout;
    assign wr_en     = (state == S_WAIT_LO) && !busy && (count != (AW+1)'(DEPTH));

    // Overflow shows up as disagreement between the two top bits of the 17-bit sum.
    assign sum17   = {xin[15], xin} + {h_q[15], h_q};
    assign sum_ovf = sum17[16] != sum17[15];
    assign sum_sat = sum_ovf ? (sum17[16] ? 16'sh8000 : 16'sh7FFF) : sum17[15:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: if (start) next_state = (nsteps == 8'd0) ? S_DONE : S_ISSUE;
            S_ISSUE:        next_state = S_WAIT_HI;
            S_WAIT_HI:      if (busy) next_state = S_WAIT_LO;
                            else if (timeout) next_state = S_DONE;
            S_WAIT_LO:      if (!busy) next_state = S_NEXT;
                            else if (timeout) next_state = S_DONE;
            S_NEXT:         next_state = last_step ? S_DONE : S_ISSUE;
            default:        next_state = S_IDLE;
        endcase
    end

    always_comb begin
        go       = 1'b0;
        running  = 1'b1;
        finished = 1'b0;
        case (state)
            S_IDLE:  running = 1'b0;
            S_DONE:  begin running = 1'b0; finished = 1'b1; end
            S_ISSUE: go = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xin      <= '0;
            stop     <= 1'b0;
            err      <= 1'b0;
            sat      <= 1'b0;
            count    <= '0;
            h_q      <= '0;
            n_q      <= '0;
            step_cnt <= '0;
            wcnt     <= '0;
        end else begin
            wcnt <= waiting ? wcnt + TW'(1) : '0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        h_q      <= h;
                        n_q      <= nsteps;
                        xin      <= x0;
                        count    <= '0;
                        step_cnt <= '0;
                        err      <= 1'b0;
                        sat      <= 1'b0;
                        // Zero- and one-step runs are already on their last step.
                        stop     <= (nsteps <= 8'd1);
                    end
                end
                S_WAIT_LO: begin
                    if (wr_en) count <= count + (AW+1)'(1);
                end
                S_NEXT: begin
                    step_cnt <= step_inc;
                    xin      <= sum_sat;
                    if (sum_ovf) sat <= 1'b1;
                    if ({1'b0, step_inc} + 9'd1 == {1'b0, n_q}) stop <= 1'b1;
                end
                default: ;
            endcase
            if (abort) begin
                err  <= 1'b1;
                stop <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[count[AW-1:0]] <= yres;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_data <= '0;
        else       rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_edo_xseq.sv
// tb/tb_edo_xseq.sv - vector table, random runs and corner sequences for edo_xseq
`timescale 1ns/1ps
module tb_edo_xseq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] x0 = '0;
    logic [15:0] h = '0;
    logic [7:0]  nsteps = '0;
    logic        busy = 1'b0;
    logic [15:0] yres = '0;
    logic        go;
    logic [15:0] xin;
    logic        stop, running, finished, err, sat;
    logic [4:0]  count;
    logic [3:0]  rd_addr = '0;
    logic [15:0] rd_data;

    int nvec = 0;
    int nfail = 0;

    logic        go_n = 1'b0;
    logic        solver_en = 1'b1;
    int          blen = 4;
    int          bcnt = 0;
    logic [15:0] yq[$];

    edo_xseq #(.DEPTH(16), .AW(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .x0(x0), .h(h), .nsteps(nsteps),
        .busy(busy), .yres(yres), .go(go), .xin(xin), .stop(stop), .running(running),
        .finished(finished), .err(err), .sat(sat), .count(count),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) go_n = go;

    // Solver stand-in: busy for blen cycles after seeing go, fresh yres when busy drops.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            bcnt = 0;
            busy = 1'b0;
        end else if (bcnt > 0) begin
            bcnt = bcnt - 1;
            if (bcnt == 0) begin
                busy = 1'b0;
                yres = 16'($urandom);
                yq.push_back(yres);
            end
        end else if (go_n && solver_en) begin
            busy = 1'b1;
            bcnt = blen;
        end
    end

    typedef struct {
        logic [15:0] x0;
        logic [15:0] h;
        logic [7:0]  n;
        int          blen;
        int          poke;
        logic [15:0] fxin;
        int          cnt;
        logic        sat;
        int          gos;
        int          cyc;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [15:0] clampq(input int v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_run(input logic [15:0] vx0, input logic [15:0] vh, input logic [7:0] vn,
                          input int vblen, input int poke,
                          output int gos, output int cyc, output int base);
        int sx0, sh;
        sx0  = int'($signed(vx0));
        sh   = int'($signed(vh));
        blen = vblen;
        base = yq.size();
        @(negedge clk);
        x0 = vx0; h = vh; nsteps = vn; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        gos = 0;
        cyc = 0;
        while (!finished && cyc < 2000) begin
            if (go) begin
                chk("go_xin", int'(xin), int'(clampq(sx0 + gos * sh)));
                chk("go_stop", int'(stop), int'(gos == int'(vn) - 1));
                chk("go_running", int'(running), 1);
                gos++;
            end
            @(negedge clk);
            cyc++;
            if (poke != 0 && cyc == 3) begin
                start = 1'b1; x0 = 16'h5555; h = 16'h1111;
            end else begin
                start = 1'b0;
            end
        end
        chk("run_reached_done", int'(finished), 1);
    endtask

    task automatic chk_buf(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rd_addr = 4'(i);
            @(negedge clk);
            chk("buf", int'(rd_data), int'(yq[base + i]));
        end
    endtask

    initial begin
        int gos, cyc, base, ecnt, tot, wt;
        logic [15:0] rx0, rh;
        logic [7:0]  rn;
        int rb;

        tbl[0] = '{16'h0100, 16'h0080, 8'd3,  4, 0, 16'h0280, 3,  1'b0, 3,  21};
        tbl[1] = '{16'h1234, 16'h0001, 8'd0,  4, 0, 16'h1234, 0,  1'b0, 0,  0};
        tbl[2] = '{16'h7F00, 16'h0200, 8'd2,  4, 0, 16'h7FFF, 2,  1'b1, 2,  14};
        tbl[3] = '{16'h8100, 16'hFE00, 8'd2,  4, 0, 16'h8000, 2,  1'b1, 2,  14};
        tbl[4] = '{16'h0000, 16'h0010, 8'd20, 4, 0, 16'h0140, 16, 1'b0, 20, 140};
        tbl[5] = '{16'hFF00, 16'h0100, 8'd1,  1, 0, 16'h0000, 1,  1'b0, 1,  4};
        tbl[6] = '{16'h0100, 16'h0100, 8'd2,  4, 1, 16'h0300, 2,  1'b0, 2,  14};

        repeat (2) @(negedge clk);
        chk("rst_go", int'(go), 0);
        chk("rst_stop", int'(stop), 0);
        chk("rst_xin", int'(xin), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_finished", int'(finished), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 7; t++) begin
            do_run(tbl[t].x0, tbl[t].h, tbl[t].n, tbl[t].blen, tbl[t].poke, gos, cyc, base);
            chk("tbl_gos", gos, tbl[t].gos);
            chk("tbl_cycles", cyc, tbl[t].cyc);
            chk("tbl_final_xin", int'(xin), int'(tbl[t].fxin));
            chk("tbl_count", int'(count), tbl[t].cnt);
            chk("tbl_sat", int'(sat), int'(tbl[t].sat));
            chk("tbl_err", int'(err), 0);
            chk("tbl_stop", int'(stop), 1);
            chk_buf(base, tbl[t].cnt);
        end

        // Reset asserted while the step is in WAIT_LO.
        @(negedge clk);
        x0 = 16'h0300; h = 16'h0010; nsteps = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_go", int'(go), 1);
        repeat (2) @(negedge clk);
        chk("mid_running", int'(running), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_go", int'(go), 0);
        chk("mid_rst_xin", int'(xin), 0);
        chk("mid_rst_stop", int'(stop), 0);
        chk("mid_rst_running", int'(running), 0);
        chk("mid_rst_finished", int'(finished), 0);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_rd_data", int'(rd_data), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", int'(running), 0);

        for (int r = 0; r < 25; r++) begin
            rx0 = 16'($urandom);
            if ($urandom_range(0, 1) == 1) rh = 16'($urandom);
            else                           rh = 16'($urandom_range(0, 511)) - 16'd256;
            rn = 8'($urandom_range(0, 20));
            rb = int'($urandom_range(1, 6));
            do_run(rx0, rh, rn, rb, 0, gos, cyc, base);
            tot  = int'($signed(rx0)) + int'(rn) * int'($signed(rh));
            ecnt = (int'(rn) > 16) ? 16 : int'(rn);
            chk("rnd_gos", gos, int'(rn));
            chk("rnd_cycles", cyc, int'(rn) * (rb + 3));
            chk("rnd_final_xin", int'(xin), int'(clampq(tot)));
            chk("rnd_sat", int'(sat), int'(tot > 32767 || tot < -32768));
            chk("rnd_count", int'(count), ecnt);
            chk("rnd_err", int'(err), 0);
            chk("rnd_stop", int'(stop), 1);
            chk_buf(base, ecnt);
        end

        // busy never rises: abort out of WAIT_HI.
        solver_en = 1'b0;
        do_run(16'h0040, 16'h0010, 8'd1, 4, 0, gos, cyc, base);
        solver_en = 1'b1;
        chk("hi_to_gos", gos, 1);
        chk("hi_to_cycles", cyc, 9);
        chk("hi_to_err", int'(err), 1);
        chk("hi_to_stop", int'(stop), 0);
        chk("hi_to_count", int'(count), 0);

        // busy stuck high: abort out of WAIT_LO.
        do_run(16'h0040, 16'h0010, 8'd1, 30, 0, gos, cyc, base);
        chk("lo_to_cycles", cyc, 10);
        chk("lo_to_err", int'(err), 1);
        chk("lo_to_stop", int'(stop), 0);
        chk("lo_to_count", int'(count), 0);
        wt = 0;
        while (busy && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        chk("solver_drained", int'(busy), 0);

        // A fresh start from DONE clears err.
        do_run(16'h0200, 16'h0100, 8'd1, 4, 0, gos, cyc, base);
        chk("restart_err", int'(err), 0);
        chk("restart_xin", int'(xin), 16'h0300);
        chk("restart_count", int'(count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/edo_xseq.md
# edo_xseq

Stimulus sequencer and result capture stage placed directly upstream/downstream of the fixed-point ODE iteration FSMD. It generates the abscissa sequence x0, x0+h, x0+2h, … (Q8.8, saturating) and issues one `go` pulse per step. It waits out the solver's `busy` window and captures the solver's `Yres` after each step into a small result buffer. On the final step it asserts `stop`, so the solver terminates cleanly.

## Interface
- `DEPTH`, 16: result buffer entries; power of two, ≥2.
- `AW`, 4: buffer address width, log2(DEPTH).
- `TIMEOUT`, 8: maximum cycles allowed in each wait state before an error abort.

- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: begin a run; sampled only in IDLE or DONE.
- `x0` in 16 signed: first abscissa, Q8.8; sampled on accepted `start`.
- `h` in 16 signed: step size, Q8.8; sampled on accepted `start`.
- `nsteps` in 8: number of solver steps; sampled on accepted `start`.
- `busy` in 1: solver busy flag.
- `yres` in 16 signed: solver result, Q8.8.
- `go` out 1: one-cycle step request to solver.
- `xin` out 16 signed: current abscissa to solver, registered.
- `stop` out 1: tells the solver the current step is the last one.
- `running` out 1: high in every state except IDLE and DONE.
- `finished` out 1: high in DONE.
- `err` out 1: sticky timeout flag; cleared on accepted `start`.
- `sat` out 1: sticky flag, set when an `xin` update saturated; cleared on accepted `start`.
- `count` out AW+1: number of results captured; saturates at DEPTH.
- `rd_addr` in AW: buffer read address.
- `rd_data` out 16 signed: registered read data; valid 1 cycle after `rd_addr`.

## Operation
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, NEXT, DONE.
- IDLE / DONE:
  - `start`=1 latches `x0`, `h`, `nsteps`, sets `xin`←`x0`, and clears `count`, step counter, `err`, `sat`.
  - If `nsteps`==0, go to DONE with no `go` issued; otherwise go to ISSUE.
- ISSUE: `go`=1 for exactly this cycle. `stop`=1 if step counter == `nsteps`−1. Next state is WAIT_HI.
- WAIT_HI: wait for `busy`=1, then go to WAIT_LO. After TIMEOUT cycles with `busy` low, set `err` and go to DONE.
- WAIT_LO: wait for `busy`=0.
  - On that cycle, write `yres` to buffer[`count`] and increment `count`. If `count`==DEPTH, drop the write and leave `count` unchanged.
  - Then go to NEXT.
  - TIMEOUT with `busy` stuck high sets `err` and goes to DONE.
- NEXT: step counter +1; `xin`←sat16(`xin`+`h`).
  - The sum is computed at 17 bits and clamped to 0x7FFF / 0x8000. Set `sat` if clamped.
  - If the new step counter == `nsteps`, go to DONE; else go to ISSUE.
- `stop` holds high from ISSUE of the last step through DONE, until the next accepted `start` or reset. It is forced low on an `err` abort.
- `xin` is stable from ISSUE until NEXT of the same step; the solver latches it while idle.
- `start` outside IDLE/DONE is ignored.
- Buffer contents are not cleared by reset or `start`. Read is independent of the FSM and legal at any time.

## Timing
- Reset values:
  - State IDLE.
  - `go`=0, `stop`=0, `xin`=0.
  - `running`=0, `finished`=0, `err`=0, `sat`=0.
  - `count`=0, `rd_data`=0.
- `start` accepted at edge k gives ISSUE (`go`=1) during cycle k+1.
- With the solver's 4-cycle busy window, one step is 7 cycles: ISSUE, WAIT_HI (1 cycle, `busy` rises), WAIT_LO (3 cycles busy + 1 capture cycle), NEXT.
- Consecutive `go` pulses are 7 cycles apart. A run of N steps reaches DONE 7N cycles after the first `go`.
- Capture happens on the first cycle `busy` is seen low. `yres` already holds the updated value on that cycle.
- Reset mid-run: outputs take reset values immediately (asynchronous), and any in-flight step is abandoned.
- `start` coincident with DONE entry: not accepted until the FSM is actually in DONE.

## Test plan
- x0=0x0100, h=0x0080, nsteps=3, solver model busy 4 cycles → `go` at cycles 1, 8, 15; `xin`=0x0100, 0x0180, 0x0200; `stop` high from cycle 15; `count`=3; `finished` at cycle 22.
- nsteps=0, `start` → DONE next cycle; no `go`; `count`=0; `stop`=1.
- x0=0x7F00, h=0x0200, nsteps=2 → second `xin`=0x7FFF, `sat`=1. Repeat with x0=0x8100, h=0xFE00 → second `xin`=0x8000, `sat`=1.
- nsteps=20, DEPTH=16 → `count` stops at 16; buffer[15] holds the 16th `yres`; run still completes 20 `go` pulses.
- `busy` tied low → `err`=1 after 8 cycles in WAIT_HI, DONE, `stop`=0. Separately, assert `reset` during WAIT_LO → all outputs at reset values in the same cycle.
- `start` pulsed during WAIT_LO → ignored; `x0`/`h` changes have no effect on the current run.
